cart_mem_responder: RTL and testbench



---
 rtl/cart_mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_cart_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_responder.sv
// Cartridge mapper bus memory responder: turns ROM/BSRAM strobe accesses into
// single-outstanding req/ack transactions on a shared 16-bit backing port.
module cart_mem_responder #(
  parameter logic [24:0] BSRAM_BASE = 25'h1000000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [23:0] rom_addr,
  input  logic [15:0] rom_d,
  input  logic        rom_ce_n,
  input  logic        rom_oe_n,
  input  logic        rom_we_n,
  input  logic        rom_word,
  output logic [15:0] rom_q,
  input  logic [19:0] bsram_addr,
  input  logic [7:0]  bsram_d,
  input  logic        bsram_ce_n,
  input  logic        bsram_oe_n,
  input  logic        bsram_we_n,
  output logic [7:0]  bsram_q,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] SRC_BW = 2'd0;
  localparam logic [1:0] SRC_RW = 2'd1;
  localparam logic [1:0] SRC_BR = 2'd2;
  localparam logic [1:0] SRC_RR = 2'd3;

  function automatic logic [1:0] byte_be(input logic word, input logic a0);
    if (word) return 2'b11;
    else if (a0) return 2'b10;
    else return 2'b01;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [15:0] d, input logic a0);
    return a0 ? d[15:8] : d[7:0];
  endfunction

  state_t      state_r, state_s;
  logic        rom_we_n_r, bsram_we_n_r;
  logic        rom_wr_pend_r, bsram_wr_pend_r;
  logic [23:0] rom_wr_addr_r;
  logic [15:0] rom_wr_d_r;
  logic        rom_wr_word_r;
  logic [19:0] bsram_wr_addr_r;
  logic [7:0]  bsram_wr_d_r;
  logic [23:0] rom_tag_r, txn_tag_r;
  logic [19:0] bsram_tag_r;
  logic        rom_tag_vld_r, bsram_tag_vld_r;
  logic [1:0]  src_r;

  logic        rom_edge_s, bsram_edge_s;
  logic        rw_req_s, bw_req_s, rr_req_s, br_req_s;
  logic [23:0] rom_rd_tag_s, rw_addr_s;
  logic [15:0] rw_d_s;
  logic        rw_word_s;
  logic [19:0] bw_addr_s;
  logic [7:0]  bw_d_s;
  logic        issue_s, done_s;
  logic [1:0]  grant_s, iss_be_s;
  logic [24:0] iss_addr_s;
  logic [15:0] iss_din_s;
  logic        iss_we_s;
  logic [23:0] iss_tag_s;

  assign rom_edge_s   = rom_we_n_r & ~rom_we_n & ~rom_ce_n;
  assign bsram_edge_s = bsram_we_n_r & ~bsram_we_n & ~bsram_ce_n;
  assign rom_rd_tag_s = {rom_addr[23:1], rom_word};
  assign rr_req_s = ~rom_ce_n & ~rom_oe_n & (~rom_tag_vld_r | (rom_tag_r != rom_rd_tag_s));
  assign br_req_s = ~bsram_ce_n & ~bsram_oe_n & (~bsram_tag_vld_r | (bsram_tag_r != bsram_addr));
  // A write edge competes in the same cycle it is seen, carrying the live bus values.
  assign rw_req_s  = rom_wr_pend_r | rom_edge_s;
  assign bw_req_s  = bsram_wr_pend_r | bsram_edge_s;
  assign rw_addr_s = rom_edge_s ? rom_addr : rom_wr_addr_r;
  assign rw_d_s    = rom_edge_s ? rom_d : rom_wr_d_r;
  assign rw_word_s = rom_edge_s ? rom_word : rom_wr_word_r;
  assign bw_addr_s = bsram_edge_s ? bsram_addr : bsram_wr_addr_r;
  assign bw_d_s    = bsram_edge_s ? bsram_d : bsram_wr_d_r;
  assign busy      = (state_r != IDLE);
  assign done_s    = (state_r == REQ) & mem_ack;

  always_ff @(posedge mclk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bw_req_s | rw_req_s | br_req_s | rr_req_s) state_s = REQ; else state_s = IDLE;
      REQ:     if (mem_ack) state_s = DONE; else state_s = REQ;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  always_comb begin
    issue_s    = 1'b0;
    grant_s    = SRC_RR;
    iss_addr_s = 25'h0000000;
    iss_din_s  = 16'h0000;
    iss_be_s   = 2'b00;
    iss_we_s   = 1'b0;
    iss_tag_s  = 24'h000000;
    if (state_r == IDLE) begin
      if (bw_req_s) begin
        issue_s    = 1'b1;
        grant_s    = SRC_BW;
        iss_addr_s = BSRAM_BASE + {5'b00000, bw_addr_s};
        iss_din_s  = {bw_d_s, bw_d_s};
        iss_be_s   = byte_be(1'b0, bw_addr_s[0]);
        iss_we_s   = 1'b1;
      end else if (rw_req_s) begin
        issue_s    = 1'b1;
        grant_s    = SRC_RW;
        iss_addr_s = {1'b0, rw_addr_s};
        iss_din_s  = rw_word_s ? rw_d_s : {rw_d_s[7:0], rw_d_s[7:0]};
        iss_be_s   = byte_be(rw_word_s, rw_addr_s[0]);
        iss_we_s   = 1'b1;
      end else if (br_req_s) begin
        issue_s    = 1'b1;
        grant_s    = SRC_BR;
        iss_addr_s = BSRAM_BASE + {5'b00000, bsram_addr};
        iss_be_s   = byte_be(1'b0, bsram_addr[0]);
        iss_tag_s  = {4'h0, bsram_addr};
      end else if (rr_req_s) begin
        issue_s    = 1'b1;
        grant_s    = SRC_RR;
        iss_addr_s = {1'b0, rom_addr};
        iss_be_s   = byte_be(rom_word, rom_addr[0]);
        iss_tag_s  = rom_rd_tag_s;
      end else begin
        issue_s = 1'b0;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      rom_we_n_r <= 1'b1;  bsram_we_n_r <= 1'b1;
      rom_wr_pend_r <= 1'b0;  bsram_wr_pend_r <= 1'b0;
      rom_wr_addr_r <= 24'h000000;  rom_wr_d_r <= 16'h0000;  rom_wr_word_r <= 1'b0;
      bsram_wr_addr_r <= 20'h00000;  bsram_wr_d_r <= 8'h00;
      rom_tag_r <= 24'h000000;  rom_tag_vld_r <= 1'b0;
      bsram_tag_r <= 20'h00000;  bsram_tag_vld_r <= 1'b0;
      txn_tag_r <= 24'h000000;  src_r <= SRC_BW;
      mem_addr <= 25'h0000000;  mem_din <= 16'h0000;  mem_be <= 2'b00;
      mem_we <= 1'b0;  mem_req <= 1'b0;
      rom_q <= 16'h0000;  bsram_q <= 8'h00;
    end else begin
      rom_we_n_r   <= rom_we_n;
      bsram_we_n_r <= bsram_we_n;
      mem_req      <= (state_s == REQ);
      if (rom_edge_s) begin
        rom_wr_addr_r <= rom_addr;  rom_wr_d_r <= rom_d;  rom_wr_word_r <= rom_word;
      end
      if (bsram_edge_s) begin
        bsram_wr_addr_r <= bsram_addr;  bsram_wr_d_r <= bsram_d;
      end
      // An issued write consumes both the pending flag and any edge of this cycle.
      if (issue_s && grant_s == SRC_RW) rom_wr_pend_r <= 1'b0;
      else if (rom_edge_s)              rom_wr_pend_r <= 1'b1;
      if (issue_s && grant_s == SRC_BW) bsram_wr_pend_r <= 1'b0;
      else if (bsram_edge_s)            bsram_wr_pend_r <= 1'b1;
      if (issue_s) begin
        mem_addr <= iss_addr_s;  mem_din <= iss_din_s;  mem_be <= iss_be_s;
        mem_we <= iss_we_s;  src_r <= grant_s;  txn_tag_r <= iss_tag_s;
      end
      if (done_s && src_r == SRC_RR) begin
        rom_tag_r     <= txn_tag_r;
        rom_tag_vld_r <= 1'b1;
        rom_q <= (mem_be == 2'b11) ? mem_dout : {8'h00, sel_byte(mem_dout, mem_addr[0])};
      end
      if (done_s && src_r == SRC_BR) begin
        bsram_tag_r     <= txn_tag_r[19:0];
        bsram_tag_vld_r <= 1'b1;
        bsram_q         <= sel_byte(mem_dout, mem_addr[0]);
      end
      // Writes win over a read completing in the same cycle.
      if (rom_edge_s || (done_s && src_r == SRC_RW))   rom_tag_vld_r   <= 1'b0;
      if (bsram_edge_s || (done_s && src_r == SRC_BW)) bsram_tag_vld_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cart_mem_responder.sv
// Scoreboard bench for cart_mem_responder: expected backing requests are queued
// as stimulus is driven and compared when the DUT raises mem_req.
module tb_cart_mem_responder;

  logic        mclk = 1'b0;
  logic        rst;
  logic [23:0] rom_addr;
  logic [15:0] rom_d;
  logic        rom_ce_n, rom_oe_n, rom_we_n, rom_word;
  logic [15:0] rom_q;
  logic [19:0] bsram_addr;
  logic [7:0]  bsram_d;
  logic        bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [7:0]  bsram_q;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_we, mem_req, mem_ack, busy;
  logic [15:0] mem_dout;

  cart_mem_responder dut (
    .mclk(mclk), .rst(rst),
    .rom_addr(rom_addr), .rom_d(rom_d), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_we_n(rom_we_n), .rom_word(rom_word), .rom_q(rom_q),
    .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n),
    .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n), .bsram_q(bsram_q),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_dout(mem_dout), .busy(busy)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [24:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] din;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   req_cnt  = 0;
  logic prev_req = 1'b0;

  // Counts rising edges of mem_req, to catch requests the scoreboard did not expect.
  always @(negedge mclk) begin
    prev_req <= mem_req;
    if (mem_req === 1'b1 && prev_req !== 1'b1) req_cnt <= req_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic push_exp(input logic [24:0] a, input logic [1:0] be, input logic we,
                          input logic [15:0] din);
    txn_t t;
    t.addr = a; t.be = be; t.we = we; t.din = din;
    exp_q.push_back(t);
  endtask

  // Waits (bounded) for mem_req, then pops and compares the expected request.
  task automatic wait_req(output int n);
    txn_t t;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    if (mem_req !== 1'b1) check_eq("req_timeout", 32'd0, 32'd1);
    else if (exp_q.size() == 0) check_eq("unexpected_req", {7'd0, mem_addr}, 32'hFFFFFFFF);
    else begin
      t = exp_q.pop_front();
      check_eq("req_addr", {7'd0, mem_addr}, {7'd0, t.addr});
      check_eq("req_be", {30'd0, mem_be}, {30'd0, t.be});
      check_eq("req_we", {31'd0, mem_we}, {31'd0, t.we});
      if (t.we) check_eq("req_din", {16'd0, mem_din}, {16'd0, t.din});
    end
  endtask

  task automatic do_ack(input int dly, input logic [15:0] d);
    tick(dly);
    mem_ack = 1'b1;
    mem_dout = d;
    tick(1);
    mem_ack = 1'b0;
  endtask

  task automatic rom_write(input logic [23:0] a, input logic [15:0] d, input logic w);
    int n;
    rom_addr = a; rom_d = d; rom_word = w; rom_ce_n = 1'b0; rom_oe_n = 1'b1;
    rom_we_n = 1'b0;
    wait_req(n);
    do_ack(1, 16'h0000);
    tick(2);
    rom_we_n = 1'b1;
    tick(3);
  endtask

  int n;
  int base_cnt;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_dout = 16'h0000;
    rom_addr = 24'h000000; rom_d = 16'h0000; rom_word = 1'b0;
    rom_ce_n = 1'b1; rom_oe_n = 1'b1; rom_we_n = 1'b1;
    bsram_addr = 20'h00000; bsram_d = 8'h00;
    bsram_ce_n = 1'b1; bsram_oe_n = 1'b1; bsram_we_n = 1'b1;
    tick(3);
    check_eq("rst_rom_q", {16'd0, rom_q}, 32'd0);
    check_eq("rst_bsram_q", {24'd0, bsram_q}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mem_fields", {mem_we, mem_be, mem_addr}, 32'd0);
    check_eq("rst_mem_din", {16'd0, mem_din}, 32'd0);
    rst = 1'b0;

    // ROM word read, ack two cycles after req
    rom_addr = 24'h000010; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
    push_exp(25'h0000010, 2'b11, 1'b0, 16'h0000);
    wait_req(n);
    check_eq("rd_latency", n, 32'd1);
    do_ack(2, 16'hA55A);
    check_eq("rom_word_q", {16'd0, rom_q}, 32'h0000A55A);
    check_eq("req_drop_after_ack", {31'd0, mem_req}, 32'd0);
    base_cnt = req_cnt;
    tick(8);
    check_eq("hold_no_req", req_cnt, base_cnt);

    // ROM byte read, then tag hit on [23:1], then word mode miss
    rom_addr = 24'h000011; rom_word = 1'b0;
    push_exp(25'h0000011, 2'b10, 1'b0, 16'h0000);
    wait_req(n);
    do_ack(1, 16'h1234);
    check_eq("rom_byte_q", {16'd0, rom_q}, 32'h00000012);
    base_cnt = req_cnt;
    rom_addr = 24'h000010;
    tick(6);
    check_eq("byte_tag_hit", req_cnt, base_cnt);
    check_eq("byte_tag_hold_q", {16'd0, rom_q}, 32'h00000012);
    rom_word = 1'b1;
    push_exp(25'h0000010, 2'b11, 1'b0, 16'h0000);
    wait_req(n);
    do_ack(0, 16'hBEEF);
    check_eq("word_tag_q", {16'd0, rom_q}, 32'h0000BEEF);

    // ROM writes (byte and word) and the resulting tag invalidation
    push_exp(25'h0000031, 2'b10, 1'b1, 16'h5C5C);
    rom_write(24'h000031, 16'hAB5C, 1'b0);
    push_exp(25'h0000032, 2'b11, 1'b1, 16'hBEEF);
    rom_write(24'h000032, 16'hBEEF, 1'b1);
    rom_addr = 24'h000010; rom_word = 1'b1; rom_oe_n = 1'b0;
    push_exp(25'h0000010, 2'b11, 1'b0, 16'h0000);
    wait_req(n);
    do_ack(0, 16'h0F0F);
    check_eq("rom_reread_q", {16'd0, rom_q}, 32'h00000F0F);
    rom_ce_n = 1'b1; rom_oe_n = 1'b1;
    tick(2);

    // BSRAM read, one 5-cycle write pulse, read again after invalidation
    bsram_addr = 20'h00003; bsram_ce_n = 1'b0; bsram_oe_n = 1'b0;
    push_exp(25'h1000003, 2'b10, 1'b0, 16'h0000);
    wait_req(n);
    do_ack(1, 16'h5500);
    check_eq("bsram_rd_q", {24'd0, bsram_q}, 32'h00000055);
    bsram_oe_n = 1'b1;
    tick(2);
    base_cnt = req_cnt;
    bsram_d = 8'h7E; bsram_we_n = 1'b0;
    push_exp(25'h1000003, 2'b10, 1'b1, 16'h7E7E);
    wait_req(n);
    do_ack(0, 16'h0000);
    tick(3);
    bsram_we_n = 1'b1;
    tick(5);
    check_eq("one_write_per_pulse", req_cnt - base_cnt, 32'd1);
    bsram_oe_n = 1'b0;
    push_exp(25'h1000003, 2'b10, 1'b0, 16'h0000);
    wait_req(n);
    do_ack(0, 16'h7E00);
    check_eq("bsram_reread_q", {24'd0, bsram_q}, 32'h0000007E);
    bsram_oe_n = 1'b1;
    tick(2);

    // Priority: BSRAM write edge and ROM read miss in the same cycle
    bsram_addr = 20'h00004; bsram_d = 8'hC3; bsram_we_n = 1'b0;
    rom_addr = 24'h000020; rom_word = 1'b1; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
    push_exp(25'h1000004, 2'b01, 1'b1, 16'hC3C3);
    push_exp(25'h0000020, 2'b11, 1'b0, 16'h0000);
    wait_req(n);
    do_ack(1, 16'h0000);
    check_eq("busy_done", {31'd0, busy}, 32'd1);
    tick(1);
    check_eq("busy_idle_gap", {31'd0, busy}, 32'd0);
    tick(1);
    check_eq("busy_second", {31'd0, busy}, 32'd1);
    wait_req(n);
    check_eq("second_req_now", n, 32'd0);
    do_ack(0, 16'h4321);
    check_eq("prio_rom_q", {16'd0, rom_q}, 32'h00004321);
    bsram_we_n = 1'b1; bsram_ce_n = 1'b1;
    tick(2);

    // Zero-wait ack with address change during REQ
    rom_addr = 24'h000040;
    push_exp(25'h0000040, 2'b11, 1'b0, 16'h0000);
    wait_req(n);
    rom_addr = 24'h000050;
    push_exp(25'h0000050, 2'b11, 1'b0, 16'h0000);
    do_ack(0, 16'h1111);
    check_eq("zero_wait_q", {16'd0, rom_q}, 32'h00001111);
    wait_req(n);
    check_eq("b2b_gap", n, 32'd2);
    do_ack(0, 16'h2222);
    check_eq("addr_change_q", {16'd0, rom_q}, 32'h00002222);

    // Reset mid-REQ with a late ack
    rom_addr = 24'h000060;
    push_exp(25'h0000060, 2'b11, 1'b0, 16'h0000);
    wait_req(n);
    rst = 1'b1; rom_ce_n = 1'b1; rom_oe_n = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_rom_q", {16'd0, rom_q}, 32'd0);
    check_eq("mid_rst_fields", {mem_we, mem_be, mem_addr}, 32'd0);
    base_cnt = req_cnt;
    mem_ack = 1'b1; mem_dout = 16'hFFFF;
    tick(1);
    mem_ack = 1'b0;
    tick(5);
    check_eq("late_ack_rom_q", {16'd0, rom_q}, 32'd0);
    check_eq("late_ack_busy", {31'd0, busy}, 32'd0);
    check_eq("late_ack_no_req", req_cnt, base_cnt);
    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
